// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit: states, opcodes and mux selects.
`default_nettype none

package riscv_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_JALR     = 4'd11;
    localparam state_t S_LUI      = 4'd12;
    localparam state_t S_AUIPC    = 4'd13;
    localparam state_t S_TRAP     = 4'd14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] sel;
        sel = IMM_I;
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: sel = IMM_I;
            OP_STORE:                   sel = IMM_S;
            OP_BRANCH:                  sel = IMM_B;
            OP_JAL:                     sel = IMM_J;
            OP_LUI, OP_AUIPC:           sel = IMM_U;
            default:                    sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond.sv
// Branch-condition evaluator: funct3 and ALU flags to taken, plus illegal flag for funct3 010/011.
`default_nettype none

module branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the RV32I multicycle core with memory wait states, trap and instret.
`default_nettype none

module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int RESULTSRC_WIDTH = 2,
    parameter int IMMSRC_WIDTH    = 3,
    parameter int CNT_WIDTH       = 32,
    parameter bit MEM_HANDSHAKE   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [6:0]                 opcode,
    input  logic [2:0]                 funct3,
    input  logic                       zero,
    input  logic                       lt,
    input  logic                       ltu,
    input  logic                       mem_ready,
    output logic                       pc_write,
    output logic                       adr_src,
    output logic                       mem_write,
    output logic                       ir_write,
    output logic                       reg_write,
    output logic [RESULTSRC_WIDTH-1:0] result_src,
    output logic [1:0]                 alu_src_a,
    output logic [1:0]                 alu_src_b,
    output logic [1:0]                 alu_op,
    output logic [IMMSRC_WIDTH-1:0]    imm_src,
    output logic                       trap,
    output logic [CNT_WIDTH-1:0]       instret,
    output logic [3:0]                 state_dbg
);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    logic w_ready;
    logic w_taken;
    logic w_br_illegal;

    logic       w_pc_update;
    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_alu_op;

    generate
        if (MEM_HANDSHAKE) begin : g_mem_hs
            assign w_ready = mem_ready;
        end else begin : g_mem_nohs
            assign w_ready = 1'b1;
        end
    endgenerate

    branch_cond u_branch_cond (
        .funct3  (funct3),
        .zero    (zero),
        .lt      (lt),
        .ltu     (ltu),
        .taken   (w_taken),
        .illegal (w_br_illegal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (w_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = w_br_illegal ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (w_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (w_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_LUI:      state_d = S_ALUWB;
            S_AUIPC:    state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // An instruction retires on the edge that brings the FSM back to FETCH.
    always_comb begin
        instret_d = instret_q;
        if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP)) begin
            instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        w_pc_update  = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                w_src_a      = SRCA_PC;
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = w_ready;
                w_pc_update  = w_ready;
            end
            S_DECODE: begin
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
            end
            S_MEMADR, S_JALR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
            end
            S_MEMREAD: w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = RES_READDATA;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_RS2;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BRANCH: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_RS2;
                w_alu_op = ALUOP_SUB;
            end
            S_JAL: begin
                w_src_a     = SRCA_OLDPC;
                w_src_b     = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            S_LUI: begin
                w_src_a = SRCA_ZERO;
                w_src_b = SRCB_IMM;
            end
            S_AUIPC: begin
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
            end
            default: ;
        endcase
    end

    assign w_pc_write = w_pc_update | ((state_q == S_BRANCH) & w_taken);

    // Write strobes are gated by rst_n so nothing is written while reset is asserted.
    assign pc_write   = w_pc_write  & rst_n;
    assign ir_write   = w_ir_write  & rst_n;
    assign reg_write  = w_reg_write & rst_n;
    assign mem_write  = w_mem_write & rst_n;
    assign adr_src    = w_adr_src;
    assign result_src = RESULTSRC_WIDTH'(w_result_src);
    assign alu_src_a  = w_src_a;
    assign alu_src_b  = w_src_b;
    assign alu_op     = w_alu_op;
    assign imm_src    = IMMSRC_WIDTH'(imm_sel(opcode));
    assign trap       = (state_q == S_TRAP);
    assign instret    = instret_q;
    assign state_dbg  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
`default_nettype none

module tb_multicycle_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic        mem_ready;
    logic        pc_write;
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [2:0]  imm_src;
    logic        trap;
    logic [31:0] instret;
    logic [3:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_control_fsm #(
        .RESULTSRC_WIDTH (2),
        .IMMSRC_WIDTH    (3),
        .CNT_WIDTH       (32),
        .MEM_HANDSHAKE   (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .trap       (trap),
        .instret    (instret),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'b0; funct3 = 3'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
        #12;
        chk("rst_state",    32'(state_dbg), 32'd0);
        chk("rst_trap",     32'(trap),      32'd0);
        chk("rst_instret",  instret,        32'd0);
        chk("rst_ir_write", 32'(ir_write),  32'd0);
        chk("rst_pc_write", 32'(pc_write),  32'd0);
        chk("rst_src_b",    32'(alu_src_b), 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // R-type: FETCH DECODE EXECR ALUWB FETCH
        opcode = 7'b0110011;
        #1;
        chk("r_fetch_state", 32'(state_dbg),  32'd0);
        chk("r_fetch_irw",   32'(ir_write),   32'd1);
        chk("r_fetch_pcw",   32'(pc_write),   32'd1);
        chk("r_fetch_res",   32'(result_src), 32'd2);
        tick();
        chk("r_dec_state",   32'(state_dbg),  32'd1);
        chk("r_dec_srca",    32'(alu_src_a),  32'd1);
        chk("r_dec_regw",    32'(reg_write),  32'd0);
        tick();
        chk("r_exec_state",  32'(state_dbg),  32'd6);
        chk("r_exec_aluop",  32'(alu_op),     32'd2);
        chk("r_exec_regw",   32'(reg_write),  32'd0);
        tick();
        chk("r_wb_state",    32'(state_dbg),  32'd8);
        chk("r_wb_regw",     32'(reg_write),  32'd1);
        tick();
        chk("r_done_state",  32'(state_dbg),  32'd0);
        chk("r_instret",     instret,         32'd1);

        // lw with two wait cycles in MEMREAD
        opcode = 7'b0000011;
        tick();
        tick();
        chk("lw_ma_state",   32'(state_dbg),  32'd2);
        chk("lw_ma_srca",    32'(alu_src_a),  32'd2);
        chk("lw_imm",        32'(imm_src),    32'd0);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1'b1;
            #1;
            chk("lw_mr_state", 32'(state_dbg), 32'd3);
            chk("lw_mr_adr",   32'(adr_src),   32'd1);
            chk("lw_mr_regw",  32'(reg_write), 32'd0);
            tick();
        end
        chk("lw_wb_state",   32'(state_dbg),  32'd4);
        chk("lw_wb_regw",    32'(reg_write),  32'd1);
        chk("lw_wb_res",     32'(result_src), 32'd1);
        tick();
        chk("lw_done_state", 32'(state_dbg),  32'd0);
        chk("lw_instret",    instret,         32'd2);

        // sw with one wait cycle
        opcode = 7'b0100011;
        tick();
        tick();
        chk("sw_imm",        32'(imm_src),    32'd1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("sw_w0_state",   32'(state_dbg),  32'd5);
        chk("sw_w0_memw",    32'(mem_write),  32'd1);
        chk("sw_w0_regw",    32'(reg_write),  32'd0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("sw_w1_state",   32'(state_dbg),  32'd5);
        chk("sw_w1_memw",    32'(mem_write),  32'd1);
        tick();
        chk("sw_done_memw",  32'(mem_write),  32'd0);
        chk("sw_instret",    instret,         32'd3);

        // bne taken / not taken, then bltu taken and bge not taken
        opcode = 7'b1100011; funct3 = 3'b001; zero = 1'b0;
        tick();
        chk("br_imm",        32'(imm_src),    32'd2);
        tick();
        chk("br_state",      32'(state_dbg),  32'd9);
        chk("bne_taken",     32'(pc_write),   32'd1);
        chk("br_aluop",      32'(alu_op),     32'd1);
        zero = 1'b1;
        #1;
        chk("bne_not_taken", 32'(pc_write),   32'd0);
        tick();
        chk("br_instret",    instret,         32'd4);
        funct3 = 3'b110; ltu = 1'b1;
        tick();
        tick();
        chk("bltu_taken",    32'(pc_write),   32'd1);
        funct3 = 3'b101; lt = 1'b1;
        #1;
        chk("bge_not_taken", 32'(pc_write),   32'd0);
        tick();
        chk("br2_instret",   instret,         32'd5);

        // jalr: DECODE JALR JAL ALUWB
        opcode = 7'b1100111; funct3 = 3'b000;
        tick();
        chk("jalr_dec",      32'(state_dbg),  32'd1);
        chk("jalr_imm",      32'(imm_src),    32'd0);
        chk("jalr_dec_pcw",  32'(pc_write),   32'd0);
        tick();
        chk("jalr_state",    32'(state_dbg),  32'd11);
        chk("jalr_pcw",      32'(pc_write),   32'd0);
        tick();
        chk("jal_state",     32'(state_dbg),  32'd10);
        chk("jal_pcw",       32'(pc_write),   32'd1);
        chk("jal_srcb",      32'(alu_src_b),  32'd2);
        tick();
        chk("jalr_wb_state", 32'(state_dbg),  32'd8);
        chk("jalr_wb_pcw",   32'(pc_write),   32'd0);
        tick();
        chk("jalr_instret",  instret,         32'd6);

        // lui
        opcode = 7'b0110111;
        tick();
        chk("lui_imm",       32'(imm_src),    32'd4);
        tick();
        chk("lui_state",     32'(state_dbg),  32'd12);
        chk("lui_srca",      32'(alu_src_a),  32'd3);
        tick();
        tick();
        chk("lui_instret",   instret,         32'd7);

        // ecall traps and freezes instret
        opcode = 7'b1110011;
        tick();
        tick();
        chk("trap_state",    32'(state_dbg),  32'd14);
        chk("trap_flag",     32'(trap),       32'd1);
        chk("trap_irw",      32'(ir_write),   32'd0);
        chk("trap_pcw",      32'(pc_write),   32'd0);
        opcode = 7'b0110011;
        tick();
        tick();
        tick();
        chk("trap_sticky",   32'(trap),       32'd1);
        chk("trap_instret",  instret,         32'd7);
        rst_n = 1'b0;
        #1;
        chk("trap_rst_state",   32'(state_dbg), 32'd0);
        chk("trap_rst_trap",    32'(trap),      32'd0);
        chk("trap_rst_instret", instret,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // reset asserted mid-MEMWRITE drops mem_write immediately
        opcode = 7'b0100011;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("mw_pre_memw",   32'(mem_write),  32'd1);
        rst_n = 1'b0;
        #1;
        chk("mw_rst_memw",   32'(mem_write),  32'd0);
        chk("mw_rst_state",  32'(state_dbg),  32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;

        // illegal branch funct3 traps from DECODE
        opcode = 7'b1100011; funct3 = 3'b010;
        tick();
        tick();
        chk("br_illegal_trap", 32'(state_dbg), 32'd14);
        chk("br_illegal_flag", 32'(trap),      32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control unit for the RV32I multicycle processor. It is the sequential successor of the single-cycle main decoder.
- A Moore FSM sequences fetch / decode / execute / memory / writeback over several cycles and drives shared ALU, memory and register-file enables.
- It adds memory wait-state handshaking, full branch-condition evaluation, JAL/JALR/LUI/AUIPC support, a sticky trap and a retired-instruction counter.

Parameters:
- RESULTSRC_WIDTH, 2, width of result_src.
- IMMSRC_WIDTH, 3, width of imm_src.
- CNT_WIDTH, 32, width of instret counter.
- MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready internally tied to 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC load enable (pc_update | branch taken)
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address
- mem_write  out  1  data-memory write strobe
- ir_write  out  1  instruction-register / OldPC load
- reg_write  out  1  register-file write
- result_src  out  RESULTSRC_WIDTH  00 ALUOut, 01 ReadData, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- imm_src  out  IMMSRC_WIDTH  000 I, 001 S, 010 B, 011 J, 100 U
- trap  out  1  sticky illegal / ECALL / EBREAK indication
- instret  out  CNT_WIDTH  retired-instruction count
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH, trap=0, instret=0. pc_write, ir_write, reg_write and mem_write are forced 0 while rst_n=0. Other outputs take FETCH values.
- imm_src is combinational from opcode:
  - I for 0000011 / 0010011 / 1100111
  - S for 0100011
  - B for 1100011
  - J for 1101111
  - U for 0110111 / 0010111
  - otherwise 000
- Default for every output not listed under a state: 0.
- Defaults for FETCH and DECODE outputs: adr_src=0, result_src=00, alu_op=00.
- States, Moore outputs and transitions:
  - FETCH: alu_src_a=00, alu_src_b=10, result_src=10. ir_write=pc_update=mem_ready. Stays in FETCH while !mem_ready; otherwise -> DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00; computes the branch/JAL target into ALUOut. Next state by opcode:
    - lw/sw -> MEMADR
    - R -> EXECR
    - I-ALU -> EXECI
    - branch -> BRANCH, but funct3 010/011 -> TRAP
    - jal -> JAL
    - jalr -> JALR
    - lui -> LUI
    - auipc -> AUIPC
    - 1110011 or unknown -> TRAP
  - MEMADR: a=10, b=01, op=00. -> MEMREAD if opcode=0000011, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then -> MEMWB.
  - MEMWB: result_src=01, reg_write=1. -> FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write is held high through wait cycles. -> FETCH on mem_ready.
  - EXECR: a=10, b=00, op=10. -> ALUWB.
  - EXECI: a=10, b=01, op=10. -> ALUWB.
  - ALUWB: result_src=00, reg_write=1. -> FETCH.
  - BRANCH: a=10, b=00, op=01, result_src=00. pc_write=taken. -> FETCH. taken by funct3:
    - 000 zero
    - 001 !zero
    - 100 lt
    - 101 !lt
    - 110 ltu
    - 111 !ltu
  - JAL: a=01, b=10, op=00, result_src=00, pc_update=1. -> ALUWB, which writes OldPC+4 to rd.
  - JALR: a=10, b=01, op=00. -> JAL; the target rs1+imm lands in ALUOut. The datapath clears bit 0.
  - LUI: a=11, b=01, op=00. -> ALUWB.
  - AUIPC: a=01, b=01, op=00. -> ALUWB.
  - TRAP: all enables 0, trap=1. Absorbing until reset.
- pc_write = pc_update | (BRANCH & taken).
- instret increments by 1 on every transition into FETCH from a non-FETCH state. It wraps modulo 2^CNT_WIDTH and never counts in TRAP.
- Latency in cycles, excluding memory waits:
  - lw 5
  - sw 4
  - R/I/lui/auipc 4
  - branch 3
  - jal 4
  - jalr 5
- Each wait cycle adds 1 at FETCH, MEMREAD or MEMWRITE.
- Reset mid-instruction returns to FETCH immediately; no partial write may occur after rst_n falls.
- When MEM_HANDSHAKE=0, mem_ready is ignored and treated as 1.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants
  - imm_src, alu_op, result_src and alu_src_a/b encodings
- One natural sub-module: branch_cond. It is combinational; funct3, zero, lt, ltu -> taken, plus an illegal flag for funct3 010/011.

Test Plan:
- Reset, then opcode=0110011 with mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB, FETCH. reg_write=1 only in cycle 4; instret=1.
- lw (0000011) with mem_ready=0 for 2 cycles in MEMREAD -> MEMREAD held 3 cycles with adr_src=1. reg_write=1 in MEMWB; total 7 cycles.
- sw (0100011) with mem_ready low for 1 cycle -> mem_write=1 for 2 consecutive cycles, reg_write never asserted.
- Branch funct3=001, zero=0 -> pc_write=1 in BRANCH. Same branch with zero=1 -> pc_write=0. funct3=110, ltu=1 -> pc_write=1.
- jalr (1100111) -> DECODE, JALR, JAL, ALUWB. pc_write=1 only in JAL; imm_src=000.
- opcode=1110011 -> TRAP, trap=1, enables 0, instret frozen. rst_n pulse mid-MEMWRITE -> mem_write drops asynchronously; state=FETCH, trap=0, instret=0.
